// File: rtl/move_input_pkg.sv
// move_input_pkg: shared command-FSM encoding, button indices and timing defaults
// for the move input front end.
package move_input_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        HOLD    = 2'd2
    } cmdState_t;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    // 10 ms of stability at a 100 MHz ClkPort
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/move_input_ctrl_debounce.sv
// btn_debounce: synchroniser, debounce filter and rising-edge detect for one
// push-button channel.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic ClkPort,
    input  logic Reset,
    input  logic btnRaw,
    output logic btnDb,
    output logic press
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] syncReg;
    logic [CW-1:0]          dbCnt;
    logic                   dbPrev;
    logic                   sync;

    assign sync = syncReg[SYNC_STAGES-1];

    always_ff @(posedge ClkPort or posedge Reset)
        if (Reset) syncReg <= '0;
        else       syncReg <= {syncReg[SYNC_STAGES-2:0], btnRaw};

    // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge ClkPort or posedge Reset)
        if (Reset) begin
            dbCnt  <= '0;
            btnDb  <= 1'b0;
            dbPrev <= 1'b0;
        end else begin
            dbPrev <= btnDb;
            if (sync == btnDb) dbCnt <= '0;
            else if (dbCnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                dbCnt <= '0;
                btnDb <= ~btnDb;
            end else dbCnt <= dbCnt + CW'(1);
        end

    assign press = btnDb & ~dbPrev;

endmodule

// File: rtl/move_input_ctrl.sv
// move_input_ctrl: debounced buttons to one-shot move commands under valid/ack,
// plus a move_tick enable. Optional auto-repeat in HOLD: MOVE_AUTOREPEAT_EN.
module move_input_ctrl
    import move_input_pkg::*;
#(
    parameter int NUM_BTNS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TICK_DIV        = 1048576
`ifdef MOVE_AUTOREPEAT_EN
    ,
    parameter int REPEAT_TICKS    = 16
`endif
) (
    input  logic                        ClkPort,
    input  logic                        Reset,
    input  logic [NUM_BTNS-1:0]         btn_raw,
    input  logic                        move_ack,
    output logic                        move_tick,
    output logic [NUM_BTNS-1:0]         btn_db,
    output logic                        move_valid,
    output logic [$clog2(NUM_BTNS)-1:0] move_idx,
    output logic                        overrun
);
    localparam int IW = $clog2(NUM_BTNS);
    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0]       tickCnt;
    logic [NUM_BTNS-1:0] press;
    logic [IW-1:0]       firstIdx;
    logic [IW-1:0]       idxNext;
    logic                overrunNext;
    cmdState_t           state;
    cmdState_t           stateNext;

    always_ff @(posedge ClkPort or posedge Reset)
        if (Reset) tickCnt <= '0;
        else       tickCnt <= (tickCnt == TW'(TICK_DIV - 1)) ? '0 : tickCnt + TW'(1);

    assign move_tick = tickCnt == TW'(TICK_DIV - 1);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : gCh
        btn_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) uCh (
            .ClkPort(ClkPort),
            .Reset  (Reset),
            .btnRaw (btn_raw[i]),
            .btnDb  (btn_db[i]),
            .press  (press[i])
        );
    end

    // Lowest-index press wins; scanning downwards leaves the smallest set bit
    always_comb begin
        firstIdx = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--)
            if (press[i]) firstIdx = IW'(i);
    end

`ifdef MOVE_AUTOREPEAT_EN
    localparam int RW = REPEAT_TICKS > 1 ? $clog2(REPEAT_TICKS) : 1;

    logic [RW-1:0] repCnt;
    logic          repHeld;
    logic          repFire;

    assign repHeld = state == HOLD && btn_db[move_idx];
    assign repFire = repHeld && move_tick && repCnt == RW'(REPEAT_TICKS - 1);

    always_ff @(posedge ClkPort or posedge Reset)
        if (Reset)                    repCnt <= '0;
        else if (!repHeld || repFire) repCnt <= '0;
        else if (move_tick)           repCnt <= repCnt + RW'(1);
`endif

    always_ff @(posedge ClkPort or posedge Reset)
        if (Reset) begin
            state    <= IDLE;
            move_idx <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= stateNext;
            move_idx <= idxNext;
            overrun  <= overrunNext;
        end

    always_comb begin
        stateNext   = state;
        idxNext     = move_idx;
        overrunNext = overrun;
        case (state)
            IDLE: begin
                if (|press) begin
                    stateNext = PENDING;
                    idxNext   = firstIdx;
                end
            end
            PENDING: begin
                if (|press)   overrunNext = 1'b1;
                if (move_ack) stateNext   = HOLD;
            end
            HOLD: begin
`ifdef MOVE_AUTOREPEAT_EN
                if (~|btn_db)     stateNext = IDLE;
                else if (repFire) stateNext = PENDING;
`else
                if (~|btn_db) stateNext = IDLE;
`endif
            end
            default: stateNext = IDLE;
        endcase
    end

    assign move_valid = state == PENDING;

endmodule

// File: tb/tb_move_input_ctrl.sv
// tb_move_input_ctrl: directed checks of tick, debounce, handshake, overrun and
// async reset with DEBOUNCE_CYCLES=4, TICK_DIV=8, SYNC_STAGES=2.
module tb_move_input_ctrl;
    import move_input_pkg::*;

    logic       ClkPort;
    logic       Reset;
    logic [3:0] btn_raw;
    logic       move_ack;
    logic       move_tick;
    logic [3:0] btn_db;
    logic       move_valid;
    logic [1:0] move_idx;
    logic       overrun;

    int tests;
    int fails;

    move_input_ctrl #(
        .NUM_BTNS       (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV       (8)
`ifdef MOVE_AUTOREPEAT_EN
        ,
        .REPEAT_TICKS   (2)
`endif
    ) dut (
        .ClkPort   (ClkPort),
        .Reset     (Reset),
        .btn_raw   (btn_raw),
        .move_ack  (move_ack),
        .move_tick (move_tick),
        .btn_db    (btn_db),
        .move_valid(move_valid),
        .move_idx  (move_idx),
        .overrun   (overrun)
    );

    initial ClkPort = 1'b0;
    always #5 ClkPort = ~ClkPort;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge ClkPort);
    endtask

`ifdef MOVE_AUTOREPEAT_EN
    int   rise[8];
    int   nr;
    logic prevValid;
`endif

    initial begin
        tests    = 0;
        fails    = 0;
        Reset    = 1'b1;
        btn_raw  = '0;
        move_ack = 1'b0;
        cycles(3);
        check("rst_valid", move_valid, 0);
        check("rst_tick", move_tick, 0);
        check("rst_db", btn_db, 0);
        check("rst_idx", move_idx, 0);
        check("rst_ovr", overrun, 0);

        // Tick: first pulse in cycle 8 after release, then every 8 cycles
        Reset = 1'b0;
        #1;
        for (int c = 1; c <= 30; c++) begin
            check("tick", move_tick, (c % 8) == 0);
            check("idle_out", {move_valid, overrun, btn_db}, 0);
            @(negedge ClkPort);
        end

        // A 3-cycle glitch must never reach btn_db
        btn_raw[BTN_LEFT] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c == 3) btn_raw[BTN_LEFT] = 1'b0;
            @(negedge ClkPort);
            check("glitch", {move_valid, btn_db}, 0);
        end

        // Held right button: db after 6 edges, valid after 7, ack on 5th valid cycle
        btn_raw[BTN_RIGHT] = 1'b1;
        cycles(6);
        check("r_db", btn_db, 4'b1000);
        check("r_valid0", move_valid, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge ClkPort);
            check("r_valid", move_valid, 1);
            check("r_idx", move_idx, BTN_RIGHT);
        end
        move_ack = 1'b1;
        @(negedge ClkPort);
        move_ack = 1'b0;
        check("r_drop", move_valid, 0);
`ifndef MOVE_AUTOREPEAT_EN
        for (int c = 0; c < 20; c++) begin
            @(negedge ClkPort);
            check("r_hold", move_valid, 0);
        end
`endif
        btn_raw[BTN_RIGHT] = 1'b0;
        cycles(6);
        check("r_rel", btn_db, 0);
        cycles(2);

        // Second press with ack held high: exactly one valid cycle
        move_ack           = 1'b1;
        btn_raw[BTN_RIGHT] = 1'b1;
        cycles(6);
        check("r2_pre", move_valid, 0);
        @(negedge ClkPort);
        check("r2_valid", move_valid, 1);
        check("r2_idx", move_idx, BTN_RIGHT);
        @(negedge ClkPort);
        check("r2_one", move_valid, 0);
        move_ack           = 1'b0;
        btn_raw[BTN_RIGHT] = 1'b0;
        cycles(8);
        check("r2_idle", {move_valid, btn_db}, 0);

        // Simultaneous down+right: LSB priority, no overrun
        btn_raw = 4'b1010;
        cycles(6);
        check("s_db", btn_db, 4'b1010);
        @(negedge ClkPort);
        check("s_valid", move_valid, 1);
        check("s_idx", move_idx, BTN_DOWN);
        check("s_ovr", overrun, 0);
        btn_raw = 4'b0000;
        cycles(6);
        check("s_rel", btn_db, 0);
        check("s_ovr2", overrun, 0);
        btn_raw = 4'b0001;
        cycles(6);
        check("o_db", btn_db, 4'b0001);
        @(negedge ClkPort);
        check("o_ovr", overrun, 1);
        check("o_idx", move_idx, BTN_DOWN);
        check("o_valid", move_valid, 1);

        // Reset mid-handshake clears outputs without waiting for a clock edge
        #2 Reset = 1'b1;
        #1;
        check("ar_valid", move_valid, 0);
        check("ar_ovr", overrun, 0);
        check("ar_db", btn_db, 0);
        btn_raw = '0;
        @(negedge ClkPort);
        Reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge ClkPort);
            check("ar_stale", {move_valid, overrun}, 0);
        end

`ifdef MOVE_AUTOREPEAT_EN
        // Held up button with instant ack: re-issued every 2 ticks = 16 cycles
        btn_raw[BTN_UP] = 1'b1;
        move_ack        = 1'b1;
        prevValid       = 1'b0;
        nr              = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge ClkPort);
            if (move_valid && !prevValid && nr < 8) begin
                rise[nr] = c;
                nr++;
                check("rep_idx", move_idx, BTN_UP);
            end
            prevValid = move_valid;
        end
        check("rep_count", nr >= 4, 1);
        for (int k = 1; k < nr - 1; k++) check("rep_gap", rise[k+1] - rise[k], 16);
        btn_raw  = '0;
        move_ack = 1'b0;
        cycles(8);
        for (int c = 0; c < 24; c++) begin
            @(negedge ClkPort);
            check("rep_stop", move_valid, 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
